pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller for the program counter register and the IF/ID and ID/EX pipeline registers of the 5-stage pipeline.
- Each cycle it selects the next fetch address: PC+4, jump target, taken-branch target, or the reset vector.
- It asserts PC stall on load-use hazards, instruction-memory wait states and halt.
- It generates pipeline flushes on redirects, holds a pending redirect across memory wait states, and keeps stall/flush performance counters.

Parameters:
- RESET_VECTOR, 32'h00000000, address loaded on reset and the PC value after reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- PCResult  in  32  current PC register value.
- ImemReady  in  1  instruction memory returned a valid instruction for PCResult this cycle.
- IdRs, IdRt  in  5 each  source registers of the instruction in ID.
- ExMemRead  in  1  instruction in EX is a load.
- ExRt  in  5  destination register of the load in EX.
- Jump  in  1  jump decoded in ID.
- JumpTarget  in  32  jump target address.
- BranchTaken  in  1  branch resolved taken in EX.
- BranchTarget  in  32  branch target address.
- Halt  in  1  halt instruction decoded in ID.
- NextPC  out  32  address input to the PC register.
- PcStall  out  1  PC hold.
- IfIdWrite  out  1  IF/ID register write enable.
- IfIdFlush  out  1  IF/ID register converted to a bubble.
- IdExFlush  out  1  ID/EX register converted to a bubble.
- Halted  out  1  sequencer is in the HALTED state.
- StallCount  out  CNT_W  cycles with PcStall=1, excluding reset and halt.
- FlushCount  out  CNT_W  redirects taken.

Behaviour:
- Outputs NextPC, PcStall, IfIdWrite and both flushes are combinational from state and inputs. Halted and the counters are registered.
- While Reset=1:
  - NextPC=RESET_VECTOR, PcStall=0, IfIdWrite=0, IfIdFlush=1, IdExFlush=1.
  - Next state RUN; pending target register cleared; counters cleared.
  - This applies even mid-wait or mid-halt.
- Load-use hazard (LU) = ExMemRead && ExRt!=0 && (ExRt==IdRs || ExRt==IdRt).
- FSM states: RUN, WAIT, REDIR_WAIT, HALTED.
- RUN, priority order (first match wins):
  1. BranchTaken:
     - ImemReady=1: NextPC=BranchTarget, PcStall=0, IfIdFlush=1, IdExFlush=1, FlushCount+1, stay RUN.
     - ImemReady=0: latch BranchTarget into the pending register, PcStall=1, IfIdFlush=1, IdExFlush=1, FlushCount+1, go REDIR_WAIT.
  2. Halt:
     - PcStall=1, IfIdWrite=0, IdExFlush=1, go HALTED.
  3. LU:
     - PcStall=1, IfIdWrite=0, IdExFlush=1, StallCount+1, stay RUN.
     - Jump is ignored this cycle and re-evaluated next cycle.
  4. Jump:
     - ImemReady=1: NextPC=JumpTarget, IfIdFlush=1, FlushCount+1.
     - ImemReady=0: same as the BranchTaken wait path (latch JumpTarget, go REDIR_WAIT).
  5. ImemReady=0:
     - PcStall=1, IfIdWrite=0, IfIdFlush=0, StallCount+1, go WAIT.
  6. Otherwise:
     - NextPC=PCResult+4 (mod 2^32; 32'hFFFFFFFC wraps to 0), PcStall=0, IfIdWrite=1.
- WAIT:
  - Hold the PC: PcStall=1, IfIdWrite=0, StallCount+1.
  - On ImemReady=1, evaluate as RUN in the same cycle and go to RUN.
  - BranchTaken in WAIT behaves as in RUN.
- REDIR_WAIT:
  - PcStall=1, NextPC=pending, IfIdFlush=1, StallCount+1.
  - On ImemReady=1: PcStall=0, NextPC=pending, go RUN.
  - A new BranchTaken arriving here overwrites the pending target (the younger redirect is impossible; the newest wins). FlushCount is not incremented again.
- HALTED:
  - PcStall=1, IfIdWrite=0, IdExFlush=1, Halted=1.
  - Exit only via Reset.
  - StallCount is frozen.
- Counters saturate at all-ones and do not wrap.
- IfIdWrite=1 only in the "otherwise" and "redirect accepted" cases. When IfIdFlush=1, the flush dominates the write.

Decomposition:
- Shared package holds:
  - state encoding constants S_RUN=2'd0, S_WAIT=2'd1, S_REDIR_WAIT=2'd2, S_HALTED=2'd3;
  - the PC increment constant 32'd4;
  - RESET_VECTOR default.
- One natural sub-module: hazard_detect, the combinational LU comparator, reusable by the forwarding unit.
- Counters stay inline.

Test Plan:
- Reset for 1 cycle, then ImemReady=1 with no hazards, PCResult stepping 0,4,8 -> NextPC 4,8,12; PcStall=0; counters 0.
- ExMemRead=1, ExRt=5, IdRs=5 for one cycle -> PcStall=1, IfIdWrite=0, IdExFlush=1, StallCount=1. With ExRt=0 -> no stall.
- BranchTaken=1, BranchTarget=32'h40, ImemReady=1 in the same cycle as Jump=1 to 32'h80 -> NextPC=32'h40, both flushes=1, FlushCount=1.
- BranchTaken with BranchTarget=32'h100 and ImemReady=0 for 3 cycles -> REDIR_WAIT with NextPC=32'h100 and PcStall=1 for 3 cycles. Release cycle has PcStall=0, NextPC=32'h100; StallCount=3.
- Halt=1 -> Halted=1 next cycle; PcStall stays 1 for 10 cycles; StallCount unchanged. Reset -> Halted=0, state RUN, NextPC=RESET_VECTOR.
- PCResult=32'hFFFFFFFC -> NextPC=0. Force more than 65535 stall cycles -> StallCount holds 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
// Holds the state encoding, the PC step and the reset vector.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_WAIT       = 2'd1,
        S_REDIR_WAIT = 2'd2,
        S_HALTED     = 2'd3
    } state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and the fetch/decode/execute datapath.
// The master side is the sequencer itself.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);

    logic [31:0]      PCResult;
    logic             ImemReady;
    logic [4:0]       IdRs;
    logic [4:0]       IdRt;
    logic             ExMemRead;
    logic [4:0]       ExRt;
    logic             Jump;
    logic [31:0]      JumpTarget;
    logic             BranchTaken;
    logic [31:0]      BranchTarget;
    logic             Halt;
    logic [31:0]      NextPC;
    logic             PcStall;
    logic             IfIdWrite;
    logic             IfIdFlush;
    logic             IdExFlush;
    logic             Halted;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        input  PCResult, ImemReady, IdRs, IdRt,
        input  ExMemRead, ExRt, Jump, JumpTarget,
        input  BranchTaken, BranchTarget, Halt,
        output NextPC, PcStall, IfIdWrite,
        output IfIdFlush, IdExFlush, Halted,
        output StallCount, FlushCount
    );

    modport slave (
        output PCResult, ImemReady, IdRs, IdRt,
        output ExMemRead, ExRt, Jump, JumpTarget,
        output BranchTaken, BranchTarget, Halt,
        input  NextPC, PcStall, IfIdWrite,
        input  IfIdFlush, IdExFlush, Halted,
        input  StallCount, FlushCount
    );

endinterface

// File: rtl/pc_sequencer_hazard_detect.sv
// Load-use hazard comparator between the load in EX and the ID sources.
// Register 0 never creates a dependency.
module pc_sequencer_hazard_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    assign lu = mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC select, stall/flush generation and redirect holding for fetch.
// Performance counters saturate instead of wrapping.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          CNT_W        = 16
) (
    input logic            Clk,
    input logic            Reset,
    pc_sequencer_if.master bus
);

    state_t           state;
    state_t           nstate;
    logic [31:0]      pending;
    logic [31:0]      tgt;
    logic             pend_ld;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             sc_inc;
    logic             fc_inc;
    logic             lu;
    logic             do_run;
    logic             redir;
    logic [31:0]      next_pc;
    logic             stall;
    logic             if_wr;
    logic             if_flush;
    logic             ex_flush;

    pc_sequencer_hazard_detect u_hazard (
        .mem_read (bus.ExMemRead),
        .ex_rt    (bus.ExRt),
        .id_rs    (bus.IdRs),
        .id_rt    (bus.IdRt),
        .lu       (lu)
    );

    // WAIT re-enters the RUN priority chain once memory answers or a branch lands
    assign do_run = (state == S_RUN) ||
                    ((state == S_WAIT) &&
                     (bus.ImemReady || bus.BranchTaken));

    assign redir = bus.BranchTaken ||
                   (bus.Jump && !bus.Halt && !lu);

    always_comb begin
        nstate   = state;
        next_pc  = bus.PCResult;
        stall    = 1'b0;
        if_wr    = 1'b0;
        if_flush = 1'b0;
        ex_flush = 1'b0;
        pend_ld  = 1'b0;
        tgt      = pending;
        sc_inc   = 1'b0;
        fc_inc   = 1'b0;
        if (Reset) begin
            next_pc  = RESET_VECTOR;
            if_flush = 1'b1;
            ex_flush = 1'b1;
            nstate   = S_RUN;
        end else if (do_run) begin
            if (redir) begin
                tgt      = bus.BranchTaken ? bus.BranchTarget
                                           : bus.JumpTarget;
                next_pc  = tgt;
                if_flush = 1'b1;
                ex_flush = bus.BranchTaken || !bus.ImemReady;
                fc_inc   = 1'b1;
                nstate   = S_RUN;
                if (!bus.ImemReady) begin
                    stall   = 1'b1;
                    sc_inc  = 1'b1;
                    pend_ld = 1'b1;
                    nstate  = S_REDIR_WAIT;
                end
            end else if (bus.Halt) begin
                stall    = 1'b1;
                ex_flush = 1'b1;
                nstate   = S_HALTED;
            end else if (lu) begin
                stall    = 1'b1;
                ex_flush = 1'b1;
                sc_inc   = 1'b1;
                nstate   = S_RUN;
            end else if (!bus.ImemReady) begin
                stall  = 1'b1;
                sc_inc = 1'b1;
                nstate = S_WAIT;
            end else begin
                next_pc = bus.PCResult + PC_INC;
                if_wr   = 1'b1;
                nstate  = S_RUN;
            end
        end else begin
            unique case (state)
                S_WAIT: begin
                    stall  = 1'b1;
                    sc_inc = 1'b1;
                end
                S_REDIR_WAIT: begin
                    if (bus.BranchTaken) begin
                        tgt     = bus.BranchTarget;
                        pend_ld = 1'b1;
                    end
                    next_pc  = tgt;
                    if_flush = 1'b1;
                    ex_flush = 1'b1;
                    if (bus.ImemReady) begin
                        if_wr  = 1'b1;
                        nstate = S_RUN;
                    end else begin
                        stall  = 1'b1;
                        sc_inc = 1'b1;
                    end
                end
                S_HALTED: begin
                    stall    = 1'b1;
                    ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_RUN;
            pending   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= nstate;
            if (pend_ld)
                pending <= tgt;
            if (sc_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (fc_inc && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.NextPC     = next_pc;
    assign bus.PcStall    = stall;
    assign bus.IfIdWrite  = if_wr;
    assign bus.IfIdFlush  = if_flush;
    assign bus.IdExFlush  = ex_flush;
    assign bus.Halted     = (state == S_HALTED);
    assign bus.StallCount = stall_cnt;
    assign bus.FlushCount = flush_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based scoreboard.
// Stimulus pushes per-cycle expectations; a monitor checks them each cycle.
module tb_pc_sequencer;

    localparam int NPC = 0;
    localparam int ST  = 1;
    localparam int WR  = 2;
    localparam int IFF = 3;
    localparam int IEF = 4;
    localparam int HLT = 5;
    localparam int SC  = 6;
    localparam int FC  = 7;

    typedef struct {
        logic [31:0] v [8];
        logic [7:0]  m;
        string       name;
    } exp_t;

    logic   Clk;
    logic   Reset;
    exp_t   e;
    exp_t   q[$];
    int     nvec;
    int     nerr;
    string  fn [8] = '{"NextPC", "PcStall", "IfIdWrite",
                       "IfIdFlush", "IdExFlush", "Halted",
                       "StallCount", "FlushCount"};

    pc_sequencer_if #(.CNT_W(16)) bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .CNT_W        (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] act(input int f);
        case (f)
            NPC:     return bus.NextPC;
            ST:      return 32'(bus.PcStall);
            WR:      return 32'(bus.IfIdWrite);
            IFF:     return 32'(bus.IfIdFlush);
            IEF:     return 32'(bus.IdExFlush);
            HLT:     return 32'(bus.Halted);
            SC:      return 32'(bus.StallCount);
            default: return 32'(bus.FlushCount);
        endcase
    endfunction

    initial begin
        exp_t r;
        logic [31:0] a;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                for (int f = 0; f < 8; f++) begin
                    if (r.m[f]) begin
                        a = act(f);
                        nvec++;
                        if (a !== r.v[f]) begin
                            nerr++;
                            $display("FAIL %s.%s: got %h, want %h",
                                     r.name, fn[f], a, r.v[f]);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", n, got, want);
        end
    endtask

    task automatic ck(input int f, input logic [31:0] val);
        e.v[f] = val;
        e.m[f] = 1'b1;
    endtask

    task automatic go(input string n);
        e.name = n;
        q.push_back(e);
        e.m = '0;
        @(posedge Clk);
        #1;
    endtask

    task automatic in_set(input logic rst, input logic [31:0] pc,
                          input logic rdy);
        Reset           = rst;
        bus.PCResult    = pc;
        bus.ImemReady   = rdy;
        bus.IdRs        = 5'd0;
        bus.IdRt        = 5'd0;
        bus.ExMemRead   = 1'b0;
        bus.ExRt        = 5'd0;
        bus.Jump        = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.Halt        = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        e.m = '0;
        for (int f = 0; f < 8; f++) e.v[f] = '0;
        bus.JumpTarget   = '0;
        bus.BranchTarget = '0;
        in_set(1'b1, 32'h0, 1'b1);
        @(posedge Clk);
        #1;

        in_set(1, 32'h1234, 1);
        #1;
        chk("reset_now.NextPC", bus.NextPC, 32'h0);
        chk("reset_now.PcStall", 32'(bus.PcStall), 32'h0);
        chk("reset_now.IfIdFlush", 32'(bus.IfIdFlush), 32'h1);
        ck(NPC, 0); ck(ST, 0); ck(WR, 0); ck(IFF, 1); ck(IEF, 1);
        go("reset");
        in_set(0, 0, 1);
        ck(NPC, 4); ck(ST, 0); ck(WR, 1); ck(IFF, 0); ck(IEF, 0);
        ck(HLT, 0); ck(SC, 0); ck(FC, 0);
        go("seq0");
        in_set(0, 4, 1);
        ck(NPC, 8); ck(ST, 0);
        go("seq4");
        in_set(0, 8, 1);
        ck(NPC, 12); ck(ST, 0); ck(SC, 0);
        go("seq8");

        in_set(0, 12, 1);
        bus.ExMemRead = 1; bus.ExRt = 5; bus.IdRs = 5;
        ck(ST, 1); ck(WR, 0); ck(IEF, 1); ck(IFF, 0);
        go("lu_rs");
        in_set(0, 12, 1);
        bus.ExMemRead = 1;
        ck(NPC, 16); ck(ST, 0); ck(WR, 1); ck(SC, 1);
        go("lu_r0");
        in_set(0, 16, 1);
        bus.ExMemRead = 1; bus.ExRt = 7; bus.IdRt = 7; bus.IdRs = 3;
        bus.Jump = 1; bus.JumpTarget = 32'h200;
        ck(ST, 1); ck(IFF, 0); ck(IEF, 1); ck(SC, 1);
        go("lu_rt_jump");
        in_set(0, 16, 1);
        bus.Jump = 1;
        ck(NPC, 32'h200); ck(ST, 0); ck(IFF, 1); ck(SC, 2); ck(FC, 0);
        go("jump");
        in_set(0, 32'h200, 1);
        ck(NPC, 32'h204); ck(FC, 1);
        go("after_jump");

        in_set(0, 32'h204, 1);
        bus.BranchTaken = 1; bus.BranchTarget = 32'h40;
        bus.Jump = 1; bus.JumpTarget = 32'h80;
        ck(NPC, 32'h40); ck(ST, 0); ck(IFF, 1); ck(IEF, 1); ck(FC, 1);
        go("br_over_jump");
        in_set(0, 32'h40, 1);
        ck(NPC, 32'h44); ck(FC, 2); ck(SC, 2);
        go("after_br");

        in_set(0, 32'h44, 0);
        bus.BranchTaken = 1; bus.BranchTarget = 32'h100;
        ck(NPC, 32'h100); ck(ST, 1); ck(IFF, 1); ck(IEF, 1);
        ck(SC, 2); ck(FC, 2);
        go("br_wait0");
        in_set(0, 32'h44, 0);
        bus.BranchTarget = 32'hDEAD;
        ck(NPC, 32'h100); ck(ST, 1); ck(IFF, 1); ck(SC, 3); ck(FC, 3);
        go("redir1");
        in_set(0, 32'h44, 0);
        ck(NPC, 32'h100); ck(ST, 1); ck(SC, 4);
        go("redir2");
        in_set(0, 32'h44, 1);
        #1;
        chk("redir_rel_now.PcStall", 32'(bus.PcStall), 32'h0);
        chk("redir_rel_now.NextPC", bus.NextPC, 32'h100);
        ck(NPC, 32'h100); ck(ST, 0); ck(IFF, 1); ck(SC, 5); ck(FC, 3);
        go("redir_rel");
        in_set(0, 32'h100, 1);
        ck(NPC, 32'h104); ck(ST, 0); ck(SC, 5); ck(FC, 3);
        go("after_redir");

        in_set(0, 32'h104, 0);
        ck(ST, 1); ck(WR, 0); ck(IFF, 0); ck(SC, 5);
        go("wait0");
        in_set(0, 32'h104, 0);
        ck(ST, 1); ck(WR, 0); ck(SC, 6);
        go("wait1");
        in_set(0, 32'h104, 1);
        ck(NPC, 32'h108); ck(ST, 0); ck(WR, 1); ck(SC, 7);
        go("wait_rel");
        in_set(0, 32'h108, 1);
        ck(NPC, 32'h10C); ck(SC, 7);
        go("after_wait");
        in_set(0, 32'h10C, 0);
        ck(ST, 1); ck(SC, 7);
        go("wait_b0");
        in_set(0, 32'h10C, 1);
        bus.BranchTaken = 1; bus.BranchTarget = 32'h300;
        ck(NPC, 32'h300); ck(ST, 0); ck(IFF, 1); ck(IEF, 1);
        ck(SC, 8); ck(FC, 3);
        go("wait_br");
        in_set(0, 32'h300, 1);
        ck(NPC, 32'h304); ck(FC, 4); ck(SC, 8);
        go("after_wait_br");

        in_set(0, 32'h304, 1);
        bus.Halt = 1;
        ck(ST, 1); ck(WR, 0); ck(IEF, 1); ck(HLT, 0); ck(SC, 8);
        go("halt");
        for (int i = 0; i < 10; i++) begin
            in_set(0, 32'h304, i[0]);
            if (i == 3) begin
                bus.BranchTaken = 1; bus.BranchTarget = 32'h900;
            end
            ck(ST, 1); ck(WR, 0); ck(IEF, 1); ck(HLT, 1);
            ck(SC, 8); ck(FC, 4);
            go("halted");
        end
        in_set(1, 32'h304, 1);
        ck(NPC, 0); ck(ST, 0); ck(WR, 0); ck(IFF, 1); ck(IEF, 1);
        ck(HLT, 1);
        go("reset_halted");
        in_set(0, 0, 1);
        ck(NPC, 4); ck(HLT, 0); ck(SC, 0); ck(FC, 0);
        go("post_reset");

        in_set(0, 32'hFFFF_FFFC, 1);
        ck(NPC, 0); ck(ST, 0);
        go("wrap");

        in_set(0, 0, 0);
        bus.BranchTaken = 1; bus.BranchTarget = 32'h500;
        ck(NPC, 32'h500); ck(ST, 1); ck(FC, 0);
        go("br_a");
        in_set(0, 0, 0);
        bus.BranchTaken = 1; bus.BranchTarget = 32'h600;
        ck(NPC, 32'h600); ck(ST, 1); ck(FC, 1); ck(SC, 1);
        go("br_b");
        in_set(0, 0, 1);
        ck(NPC, 32'h600); ck(ST, 0); ck(FC, 1); ck(SC, 2);
        go("br_b_rel");
        in_set(0, 32'h600, 1);
        ck(NPC, 32'h604); ck(FC, 1); ck(SC, 2);
        go("after_br_b");

        in_set(0, 32'h604, 0);
        bus.Jump = 1; bus.JumpTarget = 32'h700;
        ck(NPC, 32'h700); ck(ST, 1); ck(IFF, 1);
        go("jmp_wait");
        in_set(0, 32'h604, 1);
        ck(NPC, 32'h700); ck(ST, 0); ck(FC, 2); ck(SC, 3);
        go("jmp_rel");
        in_set(0, 32'h700, 1);
        ck(NPC, 32'h704); ck(SC, 3); ck(FC, 2);
        go("after_jmp");

        for (int i = 0; i < 65540; i++) begin
            in_set(0, 32'h704, 0);
            go("");
        end
        in_set(0, 32'h704, 0);
        ck(ST, 1); ck(SC, 32'hFFFF);
        go("sat");
        in_set(0, 32'h704, 0);
        ck(SC, 32'hFFFF);
        go("sat_hold");
        in_set(0, 32'h704, 1);
        ck(NPC, 32'h708); ck(ST, 0); ck(SC, 32'hFFFF);
        go("sat_rel");

        @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
